spi_sram_resp: RTL and testbench

// - SPI mode-0 responder that emulates the serial SRAM driven by the hack_cpu SPI memory master.
// - Frame, MSB first: 8-bit cmd (0x03 READ / 0x02 WRITE), 16-bit address, then data bytes.
// - Data bytes travel low byte then high byte. Holds a byte-addressed array.
// - Used in FPGA builds and benches as the memory behind the CPU's SPI port.

---
 rtl/spi_mem_pkg.sv | 15 +
 rtl/spi_resp_sync.sv | 29 ++
 rtl/spi_sram_resp.sv | 186 ++++++++++++++++++
 tb/tb_spi_sram_resp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared command codes, status byte and FSM state type for the SPI SRAM responder
package spi_mem_pkg;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_RDSR   = 8'h05;
    localparam logic [7:0] STATUS_SEQ = 8'h40;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        RD_DATA = 3'd3,
        WR_DATA = 3'd4,
        IGNORE  = 3'd5
    } spi_resp_state_t;
endpackage

// File: rtl/spi_resp_sync.sv
// spi_resp_sync: 2-flop synchronizer with single-clk rise/fall pulses on the synced level
// Ports: clk, resetb (async active-low), d (async input), q (synced level),
//        rise/fall (1-clk pulses when q changes). RST_VAL is the level q resets to.
module spi_resp_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetb,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic meta;
    logic prev;
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_sram_resp.sv
// spi_sram_resp: SPI mode-0 serial SRAM responder (READ 0x03 / WRITE 0x02, 16-bit address, byte array)
// Ports: clk, resetb (async active-low), csb_i/sclk_i/si_i (async SPI inputs),
//        so_o/so_oe_o (serial read data and its enable), wr_valid_o/wr_addr_o/wr_data_o (write commits).
// Build option: define SPI_RESP_RDSR_EN to accept RDSR (0x05), which streams STATUS_SEQ until csb rises.
module spi_sram_resp
    import spi_mem_pkg::*;
#(
    parameter int    MEM_AW    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              csb_i,
    input  logic              sclk_i,
    input  logic              si_i,
    output logic              so_o,
    output logic              so_oe_o,
    output logic              wr_valid_o,
    output logic [MEM_AW-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);
    logic csb_s, csb_rise, csb_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic si_s, si_rise, si_fall;
    logic unused_sync;
    // csb resets low so a select still held across reset release is not seen as a new frame
    spi_resp_sync #(.RST_VAL(1'b0)) u_csb (
        .clk(clk), .resetb(resetb), .d(csb_i), .q(csb_s), .rise(csb_rise), .fall(csb_fall)
    );
    spi_resp_sync #(.RST_VAL(1'b1)) u_sclk (
        .clk(clk), .resetb(resetb), .d(sclk_i), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_resp_sync #(.RST_VAL(1'b0)) u_si (
        .clk(clk), .resetb(resetb), .d(si_i), .q(si_s), .rise(si_rise), .fall(si_fall)
    );
    assign unused_sync = ^{csb_rise, sclk_s, si_rise, si_fall};

    logic [7:0]        mem [2**MEM_AW];
    logic [7:0]        rdata;
    spi_resp_state_t   state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_in;
    logic [15:0]       addr_sr;
    logic [MEM_AW-1:0] addr;
    logic              addr_hi;
    logic              rd;
    logic              ld;
    logic              armed;
    logic [7:0]        tx;
    logic              rdsr;
    logic [7:0]        byte_in;
    logic [15:0]       addr_nxt;
    logic              last;
    logic              addr_done;
    logic              wr_en;
    logic [MEM_AW-1:0] rd_idx;
    logic [7:0]        tx_reload;

    assign byte_in   = {shift_in[6:0], si_s};
    assign addr_nxt  = {addr_sr[14:0], si_s};
    assign last      = bit_cnt == 3'd7;
    assign addr_done = state == ADDR && sclk_rise && last && addr_hi;
    assign wr_en     = state == WR_DATA && sclk_rise && last;
    // read index follows the address being captured so the first byte is ready the clk after entry
    assign rd_idx    = addr_done ? addr_nxt[MEM_AW-1:0] : addr;
    assign so_o      = so_oe_o & tx[7];

`ifdef SPI_RESP_RDSR_EN
    assign tx_reload = rdsr ? STATUS_SEQ : rdata;
`else
    assign rdsr      = 1'b0;
    assign tx_reload = rdata;
`endif

    always @(posedge clk) begin
        if (wr_en)
            mem[addr] <= byte_in;
        rdata <= mem[rd_idx];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_in   <= '0;
            addr_sr    <= '0;
            addr       <= '0;
            addr_hi    <= 1'b0;
            rd         <= 1'b0;
            ld         <= 1'b0;
            armed      <= 1'b0;
            tx         <= '0;
            so_oe_o    <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
`ifdef SPI_RESP_RDSR_EN
            rdsr       <= 1'b0;
`endif
        end else begin
            wr_valid_o <= 1'b0;
            ld         <= 1'b0;
            if (sclk_rise && (state == CMD || state == ADDR || state == WR_DATA)) begin
                shift_in <= byte_in;
                bit_cnt  <= bit_cnt + 3'd1;
            end
            case (state)
                IDLE: begin
                    if (csb_fall) begin
                        state   <= CMD;
                        bit_cnt <= '0;
                        addr_hi <= 1'b0;
`ifdef SPI_RESP_RDSR_EN
                        rdsr    <= 1'b0;
`endif
                    end
                end
                CMD: begin
                    if (sclk_rise && last) begin
                        rd    <= byte_in == CMD_READ;
                        state <= (byte_in == CMD_READ || byte_in == CMD_WRITE) ? ADDR : IGNORE;
`ifdef SPI_RESP_RDSR_EN
                        if (byte_in == CMD_RDSR) begin
                            state   <= RD_DATA;
                            rdsr    <= 1'b1;
                            ld      <= 1'b1;
                            so_oe_o <= 1'b1;
                        end
`endif
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        addr_sr <= addr_nxt;
                        if (last)
                            addr_hi <= 1'b1;
                    end
                    if (addr_done) begin
                        addr    <= addr_nxt[MEM_AW-1:0];
                        state   <= rd ? RD_DATA : WR_DATA;
                        ld      <= rd;
                        so_oe_o <= rd;
                    end
                end
                RD_DATA: begin
                    if (ld) begin
                        tx      <= tx_reload;
                        armed   <= 1'b0;
                        bit_cnt <= '0;
                        if (!rdsr)
                            addr <= addr + MEM_AW'(1);
                    end else begin
                        // the fall between the last address rise and the first data rise must not shift
                        if (sclk_rise)
                            armed <= 1'b1;
                        if (sclk_fall && armed) begin
                            armed   <= 1'b0;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last) begin
                                tx <= tx_reload;
                                if (!rdsr)
                                    addr <= addr + MEM_AW'(1);
                            end else begin
                                tx <= {tx[6:0], 1'b0};
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_en) begin
                        wr_valid_o <= 1'b1;
                        wr_addr_o  <= addr;
                        wr_data_o  <= byte_in;
                        addr       <= addr + MEM_AW'(1);
                    end
                end
                default: ;
            endcase
            // a commit in the same clk still completes above; the frame then ends here
            if (state != IDLE && csb_s) begin
                state   <= IDLE;
                so_oe_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_sram_resp.sv
// tb_spi_sram_resp: bit-banged SPI master driving spi_sram_resp with queue-based scoreboard checking
module tb_spi_sram_resp;
    logic        clk = 1'b0;
    logic        resetb;
    logic        csb;
    logic        sclk;
    logic        si;
    logic        so_o;
    logic        so_oe_o;
    logic        wr_valid_o;
    logic [15:0] wr_addr_o;
    logic [7:0]  wr_data_o;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  rd_log[$];
    logic        oe_seen;
    int          rbits;
    logic [7:0]  rsh;

    spi_sram_resp dut (
        .clk(clk), .resetb(resetb), .csb_i(csb), .sclk_i(sclk), .si_i(si),
        .so_o(so_o), .so_oe_o(so_oe_o), .wr_valid_o(wr_valid_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (so_oe_o)
            oe_seen = 1'b1;
        if (resetb && wr_valid_o) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr %h data %h expected no commit", wr_addr_o, wr_data_o);
            end else begin
                chk("wr_commit", {8'h0, wr_addr_o, wr_data_o}, {8'h0, exp_wr.pop_front()});
            end
        end
    end

    always @(posedge sclk or posedge csb or negedge resetb) begin
        if (!resetb || csb) begin
            rbits = 0;
        end else if (so_oe_o) begin
            rsh = {rsh[6:0], so_o};
            rbits++;
            if (rbits == 8) begin
                rbits = 0;
                rd_log.push_back(rsh);
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h expected no read byte", rsh);
                end else begin
                    chk("rd_byte", {24'h0, rsh}, {24'h0, exp_rd.pop_front()});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bitx(input logic b);
        sclk = 1'b0;
        si = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
    endtask

    task automatic sbyte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            bitx(v[i]);
    endtask

    task automatic start_frame(input logic [7:0] cmd, input logic [15:0] a);
        csb = 1'b0;
        tick(4);
        sbyte(cmd);
        sbyte(a[15:8]);
        sbyte(a[7:0]);
    endtask

    task automatic end_frame();
        csb = 1'b1;
        si = 1'b0;
        tick(8);
    endtask

    task automatic wr_frame(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
        exp_wr.push_back({a, d0});
        exp_wr.push_back({a + 16'd1, d1});
        start_frame(8'h02, a);
        sbyte(d0);
        sbyte(d1);
        end_frame();
    endtask

    task automatic rd_frame(input logic [15:0] a, input int n, input logic [7:0] e0, input logic [7:0] e1);
        rd_log.delete();
        exp_rd.push_back(e0);
        if (n > 1)
            exp_rd.push_back(e1);
        start_frame(8'h03, a);
        for (int i = 0; i < n; i++)
            sbyte(8'h00);
        end_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        resetb = 1'b0;
        csb = 1'b1;
        sclk = 1'b1;
        si = 1'b0;
        tick(3);
        chk("rst_so", {31'h0, so_o}, 32'h0);
        chk("rst_so_oe", {31'h0, so_oe_o}, 32'h0);
        chk("rst_wr_valid", {31'h0, wr_valid_o}, 32'h0);
        chk("rst_wr_addr", {16'h0, wr_addr_o}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data_o}, 32'h0);
        resetb = 1'b1;
        tick(8);

        wr_frame(16'h0010, 8'h34, 8'h12);
        rd_frame(16'h0010, 2, 8'h34, 8'h12);
        chk("rd_word", (rd_log.size() == 2) ? {16'h0, rd_log[1], rd_log[0]} : 32'hDEAD, 32'h1234);

        wr_frame(16'hFFFF, 8'hAA, 8'h55);
        rd_frame(16'hFFFF, 2, 8'hAA, 8'h55);

        exp_wr.push_back({16'h0021, 8'h77});
        start_frame(8'h02, 16'h0021);
        sbyte(8'h77);
        end_frame();
        exp_wr.push_back({16'h0020, 8'hC3});
        start_frame(8'h02, 16'h0020);
        sbyte(8'hC3);
        for (int i = 0; i < 4; i++)
            bitx(i[0]);
        end_frame();
        rd_frame(16'h0020, 2, 8'hC3, 8'h77);

        oe_seen = 1'b0;
        start_frame(8'h9F, 16'h1234);
        sbyte(8'h56);
        end_frame();
        chk("ignore_no_oe", {31'h0, oe_seen}, 32'h0);
        rd_frame(16'h0010, 2, 8'h34, 8'h12);

        csb = 1'b0;
        tick(4);
        sbyte(8'h03);
        sbyte(8'h00);
        sbyte(8'h10);
        for (int i = 0; i < 4; i++)
            bitx(1'b0);
        chk("oe_in_read", {31'h0, so_oe_o}, 32'h1);
        resetb = 1'b0;
        #1;
        chk("oe_after_reset", {31'h0, so_oe_o}, 32'h0);
        chk("so_after_reset", {31'h0, so_o}, 32'h0);
        tick(3);
        resetb = 1'b1;
        tick(16);
        chk("oe_idle_after_reset", {31'h0, so_oe_o}, 32'h0);
        end_frame();
        rd_frame(16'h0011, 1, 8'h12, 8'h00);

`ifdef SPI_RESP_RDSR_EN
        exp_rd.push_back(8'h40);
        exp_rd.push_back(8'h40);
        csb = 1'b0;
        tick(4);
        sbyte(8'h05);
        sbyte(8'h00);
        sbyte(8'h00);
        end_frame();
`else
        oe_seen = 1'b0;
        csb = 1'b0;
        tick(4);
        sbyte(8'h05);
        sbyte(8'h00);
        sbyte(8'h00);
        end_frame();
        chk("rdsr_ignored", {31'h0, oe_seen}, 32'h0);
`endif

        chk("wr_queue_drained", exp_wr.size(), 32'h0);
        chk("rd_queue_drained", exp_rd.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
